// File: rtl/load_store_queue_pkg.sv
// Shared types and encodings for the load/store queue: funct3 sizes, FSM states
// and the queue entry layout.
package load_store_queue_pkg;

  localparam logic [2:0] LSQ_FUNCT3_B  = 3'b000;
  localparam logic [2:0] LSQ_FUNCT3_H  = 3'b001;
  localparam logic [2:0] LSQ_FUNCT3_W  = 3'b010;
  localparam logic [2:0] LSQ_FUNCT3_BU = 3'b100;
  localparam logic [2:0] LSQ_FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSQ_ST_IDLE = 2'd0,
    LSQ_ST_REQ  = 2'd1,
    LSQ_ST_RESP = 2'd2,
    LSQ_ST_WB   = 2'd3
  } lsq_state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  regd;
    logic [31:0] data;
    logic [31:0] addr;
  } lsq_entry_t;

  // funct3[1:0] carries the size for both signed and unsigned variants.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Synchronous FIFO with occupancy count; the head entry is visible
// combinationally so the consumer can decode it before popping.
module lsq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = en & push & ~full;
  assign do_pop  = en & pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are log2(DEPTH) wide, so wrap-around is free for power-of-two depths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// Unified in-order load/store queue: issues one memory access at a time,
// formats load data for write-back and reports misaligned accesses.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int C_XLEN  = 32,
  parameter int C_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  input  logic              exs_lq_wr_i,
  input  logic              exs_sq_wr_i,
  input  logic [2:0]        exs_funct3_i,
  input  logic [4:0]        exs_regd_addr_i,
  input  logic [C_XLEN-1:0] exs_regs2_data_i,
  input  logic [C_XLEN-1:0] exs_addr_i,
  output logic              exs_full_o,
  output logic              empty_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              wb_regd_wr_o,
  output logic [4:0]        wb_regd_addr_o,
  output logic [C_XLEN-1:0] wb_regd_data_o,
  input  logic              wb_ready_i,
  output logic              hvec_lmaif_o,
  output logic              hvec_smaif_o
);

  localparam int CW = $clog2(C_DEPTH) + 1;

  lsq_entry_t        entry_in;
  lsq_entry_t        head;
  logic [CW-1:0]     count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  lsq_state_t        state_q;
  lsq_state_t        state_n;
  logic              req;
  logic              wb_wr;
  logic              load_capture;
  logic [3:0]        be;
  logic [C_XLEN-1:0] wdata;
  logic [C_XLEN-1:0] lane;
  logic [C_XLEN-1:0] load_fmt;
  logic [C_XLEN-1:0] wb_data_q;

  assign entry_in = '{is_store: exs_sq_wr_i, funct3: exs_funct3_i, regd: exs_regd_addr_i,
                      data: exs_regs2_data_i, addr: exs_addr_i};

  lsq_fifo #(.WIDTH($bits(lsq_entry_t)), .DEPTH(C_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (reset_i),
    .en    (clk_en_i),
    .push  (exs_lq_wr_i | exs_sq_wr_i),
    .pop   (pop),
    .din   (entry_in),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign exs_full_o = fifo_full;
  assign empty_o    = fifo_empty & (state_q == LSQ_ST_IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       state_q <= LSQ_ST_IDLE;
    else if (clk_en_i) state_q <= state_n;
  end

  always_comb begin
    state_n      = state_q;
    pop          = 1'b0;
    req          = 1'b0;
    wb_wr        = 1'b0;
    load_capture = 1'b0;
    hvec_lmaif_o = 1'b0;
    hvec_smaif_o = 1'b0;
    case (state_q)
      LSQ_ST_IDLE: begin
        if (count != '0) begin
          if (is_misaligned(head.funct3, head.addr[1:0])) begin
            pop          = 1'b1;
            hvec_smaif_o = head.is_store;
            hvec_lmaif_o = ~head.is_store;
          end else begin
            state_n = LSQ_ST_REQ;
          end
        end
      end
      LSQ_ST_REQ: begin
        req = 1'b1;
        if (dmem_gnt_i) begin
          pop     = head.is_store;
          state_n = head.is_store ? LSQ_ST_IDLE : LSQ_ST_RESP;
        end
      end
      LSQ_ST_RESP: begin
        if (dmem_rvalid_i) begin
          load_capture = 1'b1;
          state_n      = LSQ_ST_WB;
        end
      end
      LSQ_ST_WB: begin
        wb_wr = 1'b1;
        if (wb_ready_i) begin
          pop     = 1'b1;
          state_n = LSQ_ST_IDLE;
        end
      end
      default: state_n = LSQ_ST_IDLE;
    endcase
  end

  always_comb begin
    case (head.funct3[1:0])
      2'b00:   be = 4'b0001 << head.addr[1:0];
      2'b01:   be = 4'b0011 << head.addr[1:0];
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    case (head.funct3[1:0])
      2'b00:   wdata = {4{head.data[7:0]}};
      2'b01:   wdata = {2{head.data[15:0]}};
      default: wdata = head.data;
    endcase
  end

  // The head entry stays in the queue until write-back, so its offset is still valid here.
  assign lane = dmem_rdata_i >> {head.addr[1:0], 3'b000};

  always_comb begin
    case (head.funct3)
      LSQ_FUNCT3_B:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      LSQ_FUNCT3_H:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      LSQ_FUNCT3_BU: load_fmt = {24'b0, lane[7:0]};
      LSQ_FUNCT3_HU: load_fmt = {16'b0, lane[15:0]};
      default:       load_fmt = lane;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                       wb_data_q <= '0;
    else if (clk_en_i && load_capture) wb_data_q <= load_fmt;
  end

  // Outputs are forced to zero outside their active state so stale head contents never leak.
  assign dmem_req_o     = req;
  assign dmem_we_o      = req & head.is_store;
  assign dmem_addr_o    = req ? {head.addr[C_XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o      = req ? be : 4'b0000;
  assign dmem_wdata_o   = (req & head.is_store) ? wdata : '0;
  assign wb_regd_wr_o   = wb_wr;
  assign wb_regd_addr_o = wb_wr ? head.regd : 5'd0;
  assign wb_regd_data_o = wb_wr ? wb_data_q : '0;

endmodule
